// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the IF and MA pipeline stages.
//   MA has priority. A streak limit bounds how many MA grants can pass a
//   waiting IF. A watchdog aborts a transaction that is never acked.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_if_*  / o_if_*  IF read request (level), rdata and ready level
//   i_ma_*  / o_ma_*  MA read/write request (level), rdata and ready level
//   o_mem_*           registered memory command, held until ack
//   i_mem_ack/rdata   one-cycle completion pulse with read data
//   o_timeout         sticky watchdog error flag
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    output logic [DW-1:0]   o_if_rdata,
    output logic            o_if_ready,
    input  logic            i_ma_req,
    input  logic            i_ma_we,
    input  logic [AW-1:0]   i_ma_addr,
    input  logic [DW-1:0]   i_ma_wdata,
    input  logic [DW/8-1:0] i_ma_be,
    output logic [DW-1:0]   o_ma_rdata,
    output logic            o_ma_ready,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_be,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic            o_timeout
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA} state_e;

    state_e          state_q;
    logic [SW-1:0]   streak_q;
    logic [WW-1:0]   wdog_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [BW-1:0]   mem_be_q;
    logic            timeout_q;

    logic busy, wd_expire, done, grant_ma, grant_if;

    // wdog_q holds (BUSY cycles elapsed - 1), so the abort lands in the
    // TIMEOUT-th BUSY cycle. A real ack in that same cycle wins.
    assign busy      = (state_q != IDLE);
    assign wd_expire = busy && !i_mem_ack && (wdog_q == WW'(TIMEOUT - 1));
    assign done      = busy && (i_mem_ack || wd_expire);

    // IF only overtakes a pending MA once MA has used up its streak.
    assign grant_ma  = (state_q == IDLE) && i_ma_req &&
                       (!i_if_req || (streak_q != SW'(MAX_STREAK)));
    assign grant_if  = (state_q == IDLE) && i_if_req && !grant_ma;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ma) begin
                        state_q     <= BUSY_MA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= i_ma_we;
                        mem_addr_q  <= i_ma_addr;
                        mem_wdata_q <= i_ma_wdata;
                        mem_be_q    <= i_ma_be;
                        wdog_q      <= '0;
                        if (!i_if_req)
                            streak_q <= '0;
                        else if (streak_q != SW'(MAX_STREAK))
                            streak_q <= streak_q + SW'(1);
                    end else if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= i_if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        wdog_q      <= '0;
                        streak_q    <= '0;
                    end else if (!i_if_req) begin
                        streak_q <= '0;
                    end
                end
                BUSY_IF, BUSY_MA: begin
                    if (done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (wd_expire)
                            timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Readies are levels for the hazard logic: high whenever the stage is
    // not requesting, or in the completion cycle of its own transaction.
    assign o_if_ready = !rst && (!i_if_req || ((state_q == BUSY_IF) && done));
    assign o_ma_ready = !rst && (!i_ma_req || ((state_q == BUSY_MA) && done));

    // A watchdog abort has no ack, so it naturally returns zero data.
    assign o_if_rdata = ((state_q == BUSY_IF) && i_mem_ack) ? i_mem_rdata : '0;
    assign o_ma_rdata = ((state_q == BUSY_MA) && i_mem_ack) ? i_mem_rdata : '0;

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed stimulus for mem_port_arbiter, with a transaction-level model
//   checked on every falling edge and literal expectations in the stimulus.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic            i_if_req;
    logic [AW-1:0]   i_if_addr;
    logic [DW-1:0]   o_if_rdata;
    logic            o_if_ready;
    logic            i_ma_req;
    logic            i_ma_we;
    logic [AW-1:0]   i_ma_addr;
    logic [DW-1:0]   i_ma_wdata;
    logic [DW/8-1:0] i_ma_be;
    logic [DW-1:0]   o_ma_rdata;
    logic            o_ma_ready;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_wdata;
    logic [DW/8-1:0] o_mem_be;
    logic            i_mem_ack;
    logic [DW-1:0]   i_mem_rdata;
    logic            o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
        .i_ma_req(i_ma_req), .i_ma_we(i_ma_we), .i_ma_addr(i_ma_addr),
        .i_ma_wdata(i_ma_wdata), .i_ma_be(i_ma_be),
        .o_ma_rdata(o_ma_rdata), .o_ma_ready(o_ma_ready),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the port (0 none, 1 IF, 2 MA), how many BUSY cycles
    // the current transaction has lasted, the MA-over-IF streak, and the
    // command the memory should be seeing.
    int          m_owner = 0;
    int          m_age = 0;
    int          m_streak = 0;
    bit          m_to = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;

    initial begin
        bit fin;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_owner = 0; m_age = 0; m_streak = 0; m_to = 1'b0;
                chk("rst_mem_req",  32'(o_mem_req), 32'd0);
                chk("rst_mem_we",   32'(o_mem_we), 32'd0);
                chk("rst_mem_addr", o_mem_addr, 32'd0);
                chk("rst_mem_wdata", o_mem_wdata, 32'd0);
                chk("rst_mem_be",   32'(o_mem_be), 32'd0);
                chk("rst_timeout",  32'(o_timeout), 32'd0);
                chk("rst_if_ready", 32'(o_if_ready), 32'd0);
                chk("rst_ma_ready", 32'(o_ma_ready), 32'd0);
            end else begin
                fin = (m_owner != 0) && (i_mem_ack || m_age == TO);
                chk("if_ready", 32'(o_if_ready), 32'(!i_if_req || (m_owner == 1 && fin)));
                chk("ma_ready", 32'(o_ma_ready), 32'(!i_ma_req || (m_owner == 2 && fin)));
                chk("if_rdata", o_if_rdata, (m_owner == 1 && i_mem_ack) ? i_mem_rdata : 32'd0);
                chk("ma_rdata", o_ma_rdata, (m_owner == 2 && i_mem_ack) ? i_mem_rdata : 32'd0);
                chk("mem_req",  32'(o_mem_req), 32'(m_owner != 0));
                chk("timeout",  32'(o_timeout), 32'(m_to));
                if (m_owner != 0) begin
                    chk("mem_we",   32'(o_mem_we), 32'(m_we));
                    chk("mem_addr", o_mem_addr, m_addr);
                    chk("mem_be",   32'(o_mem_be), 32'(m_be));
                    if (m_owner == 2) chk("mem_wdata", o_mem_wdata, m_wdata);
                end
                // advance to what the coming rising edge produces
                if (m_owner != 0) begin
                    if (fin) begin
                        if (!i_mem_ack) m_to = 1'b1;
                        m_owner = 0;
                    end else begin
                        m_age++;
                    end
                end else if (i_ma_req && (!i_if_req || m_streak < MS)) begin
                    m_owner = 2; m_age = 1;
                    m_we = i_ma_we; m_addr = i_ma_addr; m_wdata = i_ma_wdata; m_be = i_ma_be;
                    m_streak = !i_if_req ? 0 : (m_streak < MS ? m_streak + 1 : m_streak);
                end else if (i_if_req) begin
                    m_owner = 1; m_age = 1;
                    m_we = 1'b0; m_addr = i_if_addr; m_be = 4'hF;
                    m_streak = 0;
                end else begin
                    m_streak = 0;
                end
            end
        end
    end

    // Waits (bounded) for a memory request, acks it after lat BUSY cycles,
    // reports which requester completed and its data, and retires that request.
    task automatic serve(input int lat, input logic [31:0] d, input bit keep_ma,
                         output int who, output logic [31:0] rd);
        int n;
        n = 0; who = 0; rd = '0;
        while (!o_mem_req && n < 20) begin step(); n++; end
        if (!o_mem_req) begin
            chk("serve_req_seen", 32'(o_mem_req), 32'd1);
            return;
        end
        repeat (lat - 1) step();
        i_mem_ack = 1'b1; i_mem_rdata = d;
        #1;
        if (i_if_req && o_if_ready) begin who = 1; rd = o_if_rdata; end
        else if (i_ma_req && o_ma_ready) begin who = 2; rd = o_ma_rdata; end
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        if (who == 1) i_if_req = 1'b0;
        if (who == 2 && !keep_ma) i_ma_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int          who;
        int          k;
        logic [31:0] rd;
        int          exp_seq [6];
        exp_seq = '{2, 2, 2, 2, 1, 2};

        rst = 1'b1;
        i_if_req = 0; i_if_addr = '0;
        i_ma_req = 0; i_ma_we = 0; i_ma_addr = '0; i_ma_wdata = '0; i_ma_be = '0;
        i_mem_ack = 0; i_mem_rdata = '0;
        step();
        chk("t0_mem_req", 32'(o_mem_req), 32'd0);
        chk("t0_if_ready", 32'(o_if_ready), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // ack while idle: ignored
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
        #1;
        chk("t6_if_ready", 32'(o_if_ready), 32'd1);
        chk("t6_ma_rdata", o_ma_rdata, 32'd0);
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        chk("t6_mem_req", 32'(o_mem_req), 32'd0);
        step();

        // single IF read at 0x100, ack on the 4th BUSY cycle
        i_if_req = 1'b1; i_if_addr = 32'h100;
        step();
        chk("t1_mem_req", 32'(o_mem_req), 32'd1);
        chk("t1_mem_addr", o_mem_addr, 32'h100);
        chk("t1_mem_we", 32'(o_mem_we), 32'd0);
        chk("t1_mem_be", 32'(o_mem_be), 32'hF);
        chk("t1_ma_ready", 32'(o_ma_ready), 32'd1);
        repeat (3) begin
            chk("t1_if_wait", 32'(o_if_ready), 32'd0);
            step();
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("t1_if_ready", 32'(o_if_ready), 32'd1);
        chk("t1_if_rdata", o_if_rdata, 32'hCAFE_F00D);
        step();
        i_mem_ack = 1'b0; i_if_req = 1'b0;
        chk("t1_mem_req_clr", 32'(o_mem_req), 32'd0);
        step();

        // simultaneous IF + MA write: MA first, then IF
        i_if_req = 1'b1; i_if_addr = 32'h104;
        i_ma_req = 1'b1; i_ma_we = 1'b1; i_ma_addr = 32'h2000;
        i_ma_wdata = 32'hDEAD_BEEF; i_ma_be = 4'hF;
        step();
        chk("t2_mem_we", 32'(o_mem_we), 32'd1);
        chk("t2_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        serve(2, 32'h0, 1'b0, who, rd);
        chk("t2_first", 32'(who), 32'd2);
        serve(1, 32'h0BAD_F00D, 1'b0, who, rd);
        chk("t2_second", 32'(who), 32'd1);
        chk("t2_if_rdata", rd, 32'h0BAD_F00D);
        step();

        // IF held against continuous MA: four MA grants, then IF, then MA
        i_if_req = 1'b1; i_if_addr = 32'h108;
        i_ma_req = 1'b1; i_ma_we = 1'b0; i_ma_addr = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            serve(1 + (i % 2), 32'(i + 32'h40), 1'b1, who, rd);
            chk($sformatf("t3_grant%0d", i), 32'(who), 32'(exp_seq[i]));
        end
        i_ma_req = 1'b0;
        step();

        // ack arriving exactly in the TIMEOUT-th BUSY cycle is a normal ack
        i_if_req = 1'b1; i_if_addr = 32'h10C;
        serve(TO, 32'h7777_0001, 1'b0, who, rd);
        chk("t4a_who", 32'(who), 32'd1);
        chk("t4a_rdata", rd, 32'h7777_0001);
        chk("t4a_no_timeout", 32'(o_timeout), 32'd0);
        step();

        // ack withheld: abort in the TIMEOUT-th BUSY cycle with zero data
        i_if_req = 1'b1; i_if_addr = 32'h200;
        step();
        k = 1;
        while (!o_if_ready && k < 20) begin step(); k++; end
        chk("t4_abort_cycle", 32'(k), 32'(TO));
        chk("t4_abort_rdata", o_if_rdata, 32'd0);
        step();
        i_if_req = 1'b0;
        chk("t4_timeout_set", 32'(o_timeout), 32'd1);
        i_ma_req = 1'b1; i_ma_we = 1'b0; i_ma_addr = 32'h4000;
        serve(2, 32'hABCD_0000, 1'b0, who, rd);
        chk("t4_good_rdata", rd, 32'hABCD_0000);
        chk("t4_timeout_sticky", 32'(o_timeout), 32'd1);
        step();

        // reset in the middle of an MA transaction
        i_ma_req = 1'b1; i_ma_we = 1'b0; i_ma_addr = 32'h300;
        step();
        chk("t5_busy", 32'(o_mem_req), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("t5_req_drop", 32'(o_mem_req), 32'd0);
        chk("t5_timeout_clr", 32'(o_timeout), 32'd0);
        chk("t5_ma_ready", 32'(o_ma_ready), 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        step();
        rst = 1'b0;
        serve(2, 32'h0000_55AA, 1'b0, who, rd);
        chk("t5_regrant", 32'(who), 32'd2);
        chk("t5_rdata", rd, 32'h0000_55AA);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
